// File: rtl/alu_seq_ctrl.sv
// Issue-to-ALU sequencer: one operation in flight, multicycle FP window,
// write-back with backpressure and a sticky halt on overflow or illegal opcode.

`ifndef OP_ADD
`define OP_ADD    6'h00
`define OP_SUB    6'h01
`define OP_ADDI   6'h02
`define OP_MUL    6'h03
`define OP_AND    6'h04
`define OP_OR     6'h05
`define OP_XOR    6'h06
`define OP_SLL    6'h07
`define OP_SRL    6'h08
`define OP_SRA    6'h09
`define OP_SLT    6'h0A
`define OP_BEQ    6'h0B
`define OP_BNE    6'h0C
`define OP_FP_ADD 6'h10
`define OP_FP_SUB 6'h11
`define OP_FP_MUL 6'h12
`endif

module alu_seq_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OPCODE_WIDTH = 6,
    parameter int unsigned TAG_WIDTH    = 5,
    parameter int unsigned FP_CYCLES    = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [OPCODE_WIDTH-1:0] i_op_mode,
    input  logic [DATA_WIDTH-1:0]   i_data_a,
    input  logic [DATA_WIDTH-1:0]   i_data_b,
    input  logic [TAG_WIDTH-1:0]    i_rd,
    output logic [OPCODE_WIDTH-1:0] o_alu_op,
    output logic [DATA_WIDTH-1:0]   o_alu_a,
    output logic [DATA_WIDTH-1:0]   o_alu_b,
    input  logic [DATA_WIDTH-1:0]   i_alu_data,
    input  logic                    i_alu_overflow,
    output logic                    o_wb_valid,
    input  logic                    i_wb_ready,
    output logic [DATA_WIDTH-1:0]   o_wb_data,
    output logic [TAG_WIDTH-1:0]    o_wb_rd,
    output logic                    o_halt,
    output logic [1:0]              o_halt_cause,
    output logic [CNT_WIDTH-1:0]    o_retired
);

    localparam int unsigned EXEC_CW = 4;
    localparam logic [EXEC_CW-1:0] FP_LOAD = EXEC_CW'(FP_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_ILL  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_HALT} state_t;

    state_t                  r_state,   w_state_nxt;
    logic [EXEC_CW-1:0]      r_cnt,     w_cnt_nxt;
    logic [OPCODE_WIDTH-1:0] r_op,      w_op_nxt;
    logic [DATA_WIDTH-1:0]   r_a,       w_a_nxt;
    logic [DATA_WIDTH-1:0]   r_b,       w_b_nxt;
    logic [TAG_WIDTH-1:0]    r_rd,      w_rd_nxt;
    logic [DATA_WIDTH-1:0]   r_wb_data, w_wb_data_nxt;
    logic [1:0]              r_cause,   w_cause_nxt;
    logic [CNT_WIDTH-1:0]    r_retired, w_retired_nxt;

    function automatic logic f_is_legal(input logic [OPCODE_WIDTH-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            `OP_ADD, `OP_SUB, `OP_ADDI, `OP_MUL,
            `OP_AND, `OP_OR, `OP_XOR,
            `OP_SLL, `OP_SRL, `OP_SRA,
            `OP_SLT, `OP_BEQ, `OP_BNE,
            `OP_FP_ADD, `OP_FP_SUB, `OP_FP_MUL: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic f_is_fp(input logic [OPCODE_WIDTH-1:0] op);
        logic fp;
        fp = 1'b0;
        case (op)
            `OP_FP_ADD, `OP_FP_SUB, `OP_FP_MUL: fp = 1'b1;
            default:                            fp = 1'b0;
        endcase
        return fp;
    endfunction

    // Only these opcodes can raise a halting overflow; the flag is noise otherwise.
    function automatic logic f_is_int_arith(input logic [OPCODE_WIDTH-1:0] op);
        logic ia;
        ia = 1'b0;
        case (op)
            `OP_ADD, `OP_SUB, `OP_ADDI, `OP_MUL: ia = 1'b1;
            default:                             ia = 1'b0;
        endcase
        return ia;
    endfunction

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_op_nxt      = r_op;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_rd_nxt      = r_rd;
        w_wb_data_nxt = r_wb_data;
        w_cause_nxt   = r_cause;
        w_retired_nxt = r_retired;

        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    if (f_is_legal(i_op_mode)) begin
                        w_op_nxt    = i_op_mode;
                        w_a_nxt     = i_data_a;
                        w_b_nxt     = i_data_b;
                        w_rd_nxt    = i_rd;
                        w_cnt_nxt   = f_is_fp(i_op_mode) ? FP_LOAD : '0;
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_cause_nxt = CAUSE_ILL;
                        w_state_nxt = S_HALT;
                    end
                end
            end

            S_EXEC: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (i_alu_overflow && f_is_int_arith(r_op)) begin
                    w_cause_nxt = CAUSE_OVF;
                    w_state_nxt = S_HALT;
                end else begin
                    w_wb_data_nxt = i_alu_data;
                    w_state_nxt   = S_WB;
                end
            end

            S_WB: begin
                if (i_wb_ready) begin
                    if (r_retired != '1) begin
                        w_retired_nxt = r_retired + 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
            end

            S_HALT: begin
                w_state_nxt = S_HALT;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rd      <= '0;
            r_wb_data <= '0;
            r_cause   <= CAUSE_NONE;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_op      <= w_op_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_rd      <= w_rd_nxt;
            r_wb_data <= w_wb_data_nxt;
            r_cause   <= w_cause_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    assign o_ready      = (r_state == S_IDLE);
    assign o_wb_valid   = (r_state == S_WB);
    assign o_halt       = (r_state == S_HALT);
    assign o_halt_cause = r_cause;
    assign o_alu_op     = r_op;
    assign o_alu_a      = r_a;
    assign o_alu_b      = r_b;
    assign o_wb_data    = r_wb_data;
    assign o_wb_rd      = r_rd;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU model on the o_alu_* side.
// A 4-bit retire counter lets the table run reach saturation.

module tb_alu_seq_ctrl;

    localparam int unsigned DW  = 32;
    localparam int unsigned OW  = 6;
    localparam int unsigned TW  = 5;
    localparam int unsigned FPC = 2;
    localparam int unsigned CW  = 4;

    localparam logic [5:0] OPC_ADD    = 6'h00;
    localparam logic [5:0] OPC_SUB    = 6'h01;
    localparam logic [5:0] OPC_ADDI   = 6'h02;
    localparam logic [5:0] OPC_MUL    = 6'h03;
    localparam logic [5:0] OPC_AND    = 6'h04;
    localparam logic [5:0] OPC_OR     = 6'h05;
    localparam logic [5:0] OPC_XOR    = 6'h06;
    localparam logic [5:0] OPC_SLL    = 6'h07;
    localparam logic [5:0] OPC_SRL    = 6'h08;
    localparam logic [5:0] OPC_SRA    = 6'h09;
    localparam logic [5:0] OPC_SLT    = 6'h0A;
    localparam logic [5:0] OPC_BEQ    = 6'h0B;
    localparam logic [5:0] OPC_BNE    = 6'h0C;
    localparam logic [5:0] OPC_FP_ADD = 6'h10;
    localparam logic [5:0] OPC_FP_SUB = 6'h11;
    localparam logic [5:0] OPC_FP_MUL = 6'h12;
    localparam logic [5:0] OPC_BAD    = 6'h3F;

    logic          clk, rst_n, valid, ready, wb_valid, wb_ready, halt;
    logic [OW-1:0] op_mode, alu_op;
    logic [DW-1:0] data_a, data_b, alu_a, alu_b, alu_data, wb_data;
    logic [TW-1:0] rd, wb_rd;
    logic          alu_ovf, force_ovf;
    logic [1:0]    halt_cause;
    logic [CW-1:0] retired;

    logic signed [63:0] prod;

    int n_vec  = 0;
    int n_fail = 0;
    int exp_ret = 0;

    alu_seq_ctrl #(
        .DATA_WIDTH   (DW),
        .OPCODE_WIDTH (OW),
        .TAG_WIDTH    (TW),
        .FP_CYCLES    (FPC),
        .CNT_WIDTH    (CW)
    ) u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (valid),
        .o_ready        (ready),
        .i_op_mode      (op_mode),
        .i_data_a       (data_a),
        .i_data_b       (data_b),
        .i_rd           (rd),
        .o_alu_op       (alu_op),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .i_alu_data     (alu_data),
        .i_alu_overflow (alu_ovf),
        .o_wb_valid     (wb_valid),
        .i_wb_ready     (wb_ready),
        .o_wb_data      (wb_data),
        .o_wb_rd        (wb_rd),
        .o_halt         (halt),
        .o_halt_cause   (halt_cause),
        .o_retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU; FP ops only know the handful of operand pairs used here.
    always_comb begin
        alu_data = 32'hDEAD_BEEF;
        alu_ovf  = 1'b0;
        prod     = '0;
        case (alu_op)
            OPC_ADD, OPC_ADDI: begin
                alu_data = alu_a + alu_b;
                alu_ovf  = (alu_a[31] == alu_b[31]) && (alu_data[31] != alu_a[31]);
            end
            OPC_SUB: begin
                alu_data = alu_a - alu_b;
                alu_ovf  = (alu_a[31] != alu_b[31]) && (alu_data[31] != alu_a[31]);
            end
            OPC_MUL: begin
                prod     = $signed(alu_a) * $signed(alu_b);
                alu_data = prod[31:0];
                alu_ovf  = (prod[63:32] != {32{prod[31]}});
            end
            OPC_AND: alu_data = alu_a & alu_b;
            OPC_OR:  alu_data = alu_a | alu_b;
            OPC_XOR: alu_data = alu_a ^ alu_b;
            OPC_SLL: alu_data = alu_a << alu_b[4:0];
            OPC_SRL: alu_data = alu_a >> alu_b[4:0];
            OPC_SRA: alu_data = $signed(alu_a) >>> alu_b[4:0];
            OPC_SLT: alu_data = {31'd0, $signed(alu_a) < $signed(alu_b)};
            OPC_BEQ: alu_data = {31'd0, alu_a == alu_b};
            OPC_BNE: alu_data = {31'd0, alu_a != alu_b};
            OPC_FP_MUL:
                if (alu_a == 32'h4000_0000 && alu_b == 32'h4040_0000) alu_data = 32'h40C0_0000;
            OPC_FP_ADD:
                if (alu_a == 32'h4000_0000 && alu_b == 32'h4040_0000) alu_data = 32'h40A0_0000;
            OPC_FP_SUB:
                if (alu_a == 32'h4040_0000 && alu_b == 32'h4000_0000) alu_data = 32'h3F80_0000;
            default: alu_data = 32'hDEAD_BEEF;
        endcase
        if (force_ovf) alu_ovf = 1'b1;
    end

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        fovf;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        exp_ret = 0;
        tick();
    endtask

    task automatic bump_ret();
        if (exp_ret < (1 << CW) - 1) exp_ret++;
    endtask

    // Presents the request for one edge; returns #1 after the accepting edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        valid   = 1'b1;
        op_mode = op;
        data_a  = a;
        data_b  = b;
        rd      = r;
        tick();
        valid   = 1'b0;
        op_mode = '0;
        data_a  = '0;
        data_b  = '0;
        rd      = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        force_ovf = v.fovf;
        wb_ready  = 1'b1;
        issue(v.op, v.a, v.b, v.rd);
        check("ready_low_in_exec", ready, 1'b0);
        cyc = 0;
        while (!wb_valid && cyc < 20) begin
            check("alu_op_hold", alu_op, v.op);
            check("alu_a_hold", alu_a, v.a);
            check("alu_b_hold", alu_b, v.b);
            tick();
            cyc++;
        end
        check("latency", cyc, v.lat);
        check("wb_data", wb_data, v.exp);
        check("wb_rd", wb_rd, v.rd);
        force_ovf = 1'b0;
        tick();
        bump_ret();
        check("retired", retired, exp_ret);
        check("wb_valid_drop", wb_valid, 1'b0);
        check("ready_after_wb", ready, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        valid     = 1'b0;
        op_mode   = '0;
        data_a    = '0;
        data_b    = '0;
        rd        = '0;
        wb_ready  = 1'b1;
        force_ovf = 1'b0;

        vecs[0]  = '{OPC_ADD,    32'd5,          32'd7,          5'd3,  1'b0, 1,   32'd12};
        vecs[1]  = '{OPC_SUB,    32'd10,         32'd3,          5'd4,  1'b0, 1,   32'd7};
        vecs[2]  = '{OPC_ADDI,   32'hFFFF_FFFF,  32'd1,          5'd5,  1'b0, 1,   32'd0};
        vecs[3]  = '{OPC_MUL,    32'd6,          32'd7,          5'd6,  1'b0, 1,   32'd42};
        vecs[4]  = '{OPC_AND,    32'hFF00_FF00,  32'h0FF0_0FF0,  5'd7,  1'b0, 1,   32'h0F00_0F00};
        vecs[5]  = '{OPC_OR,     32'h0000_00F0,  32'h0000_000F,  5'd8,  1'b0, 1,   32'h0000_00FF};
        vecs[6]  = '{OPC_XOR,    32'hAAAA_5555,  32'hFFFF_0000,  5'd9,  1'b1, 1,   32'h5555_5555};
        vecs[7]  = '{OPC_SLL,    32'd1,          32'd4,          5'd10, 1'b0, 1,   32'd16};
        vecs[8]  = '{OPC_SRL,    32'h80,         32'd3,          5'd11, 1'b0, 1,   32'h10};
        vecs[9]  = '{OPC_SRA,    32'h8000_0000,  32'd4,          5'd12, 1'b0, 1,   32'hF800_0000};
        vecs[10] = '{OPC_SLT,    32'hFFFF_FFFF,  32'd5,          5'd13, 1'b0, 1,   32'd1};
        vecs[11] = '{OPC_BEQ,    32'd9,          32'd9,          5'd14, 1'b0, 1,   32'd1};
        vecs[12] = '{OPC_BNE,    32'd9,          32'd9,          5'd15, 1'b0, 1,   32'd0};
        vecs[13] = '{OPC_FP_MUL, 32'h4000_0000,  32'h4040_0000,  5'd16, 1'b0, FPC, 32'h40C0_0000};
        vecs[14] = '{OPC_FP_ADD, 32'h4000_0000,  32'h4040_0000,  5'd17, 1'b1, FPC, 32'h40A0_0000};
        vecs[15] = '{OPC_FP_SUB, 32'h4040_0000,  32'h4000_0000,  5'd31, 1'b0, FPC, 32'h3F80_0000};

        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_halt", halt, 1'b0);
        check("rst_cause", halt_cause, 2'b00);
        check("rst_retired", retired, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", wb_rd, 0);
        do_reset();

        // Sixteen write-backs also drive the 4-bit retire counter into saturation.
        for (int i = 0; i < 16; i++) run_vec(vecs[i]);
        check("retired_saturated", retired, 4'hF);

        // Reset while an FP op is in its multicycle window.
        issue(OPC_FP_MUL, 32'h4000_0000, 32'h4040_0000, 5'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready, 1'b1);
        check("midrst_wb_valid", wb_valid, 1'b0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_retired", retired, 0);
        tick();
        rst_n = 1'b1;
        exp_ret = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_wb", wb_valid, 1'b0);
        end
        run_vec(vecs[5]);

        // Write-back stalled for four cycles.
        wb_ready = 1'b0;
        issue(OPC_SUB, 32'd10, 32'd3, 5'd21);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_wb_valid", wb_valid, 1'b1);
            check("bp_wb_data", wb_data, 32'd7);
            check("bp_wb_rd", wb_rd, 5'd21);
            check("bp_ready", ready, 1'b0);
            check("bp_retired_hold", retired, exp_ret);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        bump_ret();
        check("bp_retired", retired, exp_ret);
        check("bp_ready_after", ready, 1'b1);
        tick();
        check("bp_retired_once", retired, exp_ret);

        // Signed ADD overflow halts with no write-back and ignores later requests.
        issue(OPC_ADD, 32'h7FFF_FFFF, 32'd1, 5'd1);
        tick();
        check("ovf_halt", halt, 1'b1);
        check("ovf_cause", halt_cause, 2'b01);
        check("ovf_wb_valid", wb_valid, 1'b0);
        valid   = 1'b1;
        op_mode = OPC_OR;
        data_a  = 32'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ovf_ready", ready, 1'b0);
            check("ovf_halt_sticky", halt, 1'b1);
            check("ovf_wb_valid_off", wb_valid, 1'b0);
            check("ovf_alu_op_kept", alu_op, OPC_ADD);
            check("ovf_retired_kept", retired, exp_ret);
        end
        valid = 1'b0;

        // Illegal opcode: no operand latch, counter untouched.
        do_reset();
        check("rst_clears_halt", halt, 1'b0);
        run_vec(vecs[5]);
        issue(OPC_BAD, 32'h1234, 32'h5678, 5'd9);
        check("ill_halt", halt, 1'b1);
        check("ill_cause", halt_cause, 2'b10);
        check("ill_alu_op_kept", alu_op, OPC_OR);
        check("ill_alu_a_kept", alu_a, 32'hF0);
        check("ill_retired", retired, 1);
        tick();
        check("ill_wb_valid", wb_valid, 1'b0);

        // MUL whose product exceeds 32 signed bits.
        do_reset();
        issue(OPC_MUL, 32'h0001_0000, 32'h0001_0000, 5'd3);
        tick();
        check("mulovf_halt", halt, 1'b1);
        check("mulovf_cause", halt_cause, 2'b01);
        check("mulovf_retired", retired, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer between the instruction-issue stage and the combinational ALU.
- Accepts one operation at a time over a valid/ready handshake and registers its operands into the ALU.
- Holds FP operations for a configurable multicycle window, captures the result and overflow, and presents a write-back with backpressure.
- Enters a sticky halt on integer overflow or an illegal opcode.

Parameters:
DATA_WIDTH, 32, operand/result width
OPCODE_WIDTH, 6, opcode width (matches the `OP_* defines)
TAG_WIDTH, 5, destination register tag width
FP_CYCLES, 2, ALU evaluation cycles for `OP_FP_ADD/`OP_FP_SUB/`OP_FP_MUL (legal range 1..15)
CNT_WIDTH, 16, retired-operation counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  request valid
o_ready  out  1  controller can accept a request
i_op_mode  in  OPCODE_WIDTH  opcode
i_data_a  in  DATA_WIDTH  operand A
i_data_b  in  DATA_WIDTH  operand B / immediate / shift amount
i_rd  in  TAG_WIDTH  destination tag
o_alu_op  out  OPCODE_WIDTH  registered opcode to ALU
o_alu_a  out  DATA_WIDTH  registered operand A to ALU
o_alu_b  out  DATA_WIDTH  registered operand B to ALU
i_alu_data  in  DATA_WIDTH  ALU result
i_alu_overflow  in  1  ALU overflow flag
o_wb_valid  out  1  write-back valid
i_wb_ready  in  1  write-back consumer ready
o_wb_data  out  DATA_WIDTH  captured result
o_wb_rd  out  TAG_WIDTH  captured tag
o_halt  out  1  sticky halt
o_halt_cause  out  2  00 none, 01 overflow, 10 illegal opcode
o_retired  out  CNT_WIDTH  count of completed write-backs, saturating

Behaviour:
- Reset: i_clk and i_rst_n as named; reset is asynchronous, active-low. State S_IDLE, all outputs 0 except o_ready=1, o_retired=0, o_halt_cause=00. A reset mid-operation discards the operation in flight; no write-back is produced.
- States: S_IDLE, S_EXEC, S_WB, S_HALT.
- S_IDLE:
  - o_ready=1.
  - On i_valid at a rising edge: latch op/a/b/rd into the o_alu_* registers and the tag register.
  - Load exec counter with FP_CYCLES-1 for FP opcodes, else 0.
  - Legal opcode: go to S_EXEC.
  - Illegal opcode (any not covered by `OP_*): no latch of operands, go to S_HALT with cause 10.
- S_EXEC:
  - o_ready=0; o_alu_* held stable for the whole state.
  - Counter>0: decrement and stay.
  - Counter==0 and integer overflow (i_alu_overflow=1 on `OP_ADD/`OP_SUB/`OP_ADDI/`OP_MUL): go to S_HALT, cause 01, no write-back.
  - Counter==0 otherwise: capture i_alu_data into o_wb_data, go to S_WB.
  - i_alu_overflow is ignored for all non-integer-arithmetic opcodes.
- S_WB:
  - o_wb_valid=1; o_wb_data and o_wb_rd stable until the handshake.
  - On i_wb_ready: o_retired++ (holds at all-ones), go to S_IDLE.
  - No new request is accepted in the same edge as the write-back handshake; o_ready rises the following cycle.
- S_HALT:
  - o_halt=1, o_ready=0, o_wb_valid=0.
  - Exit only via reset; o_halt_cause is frozen on entry.
- Latency: accept at edge E0, then o_wb_valid high after edge E0+N with N=1 for integer ops and N=FP_CYCLES for FP ops.
- Throughput: at most one operation per N+2 cycles with i_wb_ready held high.
- o_alu_* retain the last operation's values outside S_EXEC and do not return to 0.
- i_valid deasserted mid-transfer has no effect; inputs are sampled only in S_IDLE.
- `OP_BEQ/`OP_BNE/`OP_SLT/shift/logic results are passed through unmodified and write back normally.

Test Plan:
- `OP_ADD` a=5, b=7, rd=3, i_wb_ready=1 -> o_wb_valid one cycle after accept; data=12, rd=3; o_retired=1; o_ready back the cycle after the handshake.
- `OP_FP_MUL` a=0x40000000 (2.0), b=0x40400000 (3.0), FP_CYCLES=2 -> o_alu_* stable 2 cycles, o_wb_data=0x40C00000 two cycles after accept.
- `OP_ADD` a=0x7FFFFFFF, b=1 -> o_halt=1, cause=01, no o_wb_valid; subsequent i_valid ignored, o_ready=0 until reset.
- Opcode 6'h3F -> o_halt=1, cause=10 the cycle after accept; o_retired unchanged.
- `OP_SUB` a=10, b=3, i_wb_ready held 0 for 4 cycles then 1 -> o_wb_valid held 4+ cycles with data=7, rd stable; exactly one retirement counted.
- FP op accepted, then i_rst_n pulsed low during S_EXEC -> outputs immediately at reset values, no write-back; the next `OP_OR` a=0xF0, b=0x0F yields 0xFF.
